switch_scheduler: RTL and testbench
===================================

# switch_scheduler

Parametrised packet scheduler for the switch datapath. It sits between the per-port input packet RAMs and the per-port output RAMs. It reads NPORTS input queues, routes each packet whole to the output port named in its header word, and arbitrates round-robin when several inputs contend for one output. It adds four things the fixed 3-port scheduler lacks: N-port/width generality, wrap-safe empty detection, mid-packet stall on empty input, and discard of packets with an invalid destination.

## Interface
- NPORTS, 3, number of input and output ports (2..8); DW = $clog2(NPORTS)
- DATA_W, 32, packet word width (≥ DW+1)
- ADDR_W, 12, input RAM address width
- PERIOD, 3, clocks per issue slot (≥ 2; gives RAM read latency)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  advances slot counter; low freezes scheduler
- in_data  in  NPORTS*DATA_W  word at in_rd_addr[i] from input RAM i, slice i
- in_wr_addr  in  NPORTS*ADDR_W  write pointer of input RAM i
- in_rd_addr  out  NPORTS*ADDR_W  read pointer to input RAM i
- in_rden  out  NPORTS  input RAM read enables
- out_data  out  NPORTS*DATA_W  word to output RAM o
- out_wr  out  NPORTS  one-cycle write strobe to output RAM o
- out_busy  out  NPORTS  output o locked to a packet in progress
- drop_count  out  16  packets discarded, saturating

## Operation
- Slot counter 0..PERIOD-1 increments when enable=1 and wraps. An issue occurs on the cycle the counter is at PERIOD-1 with enable=1. No other cycle changes routing state.
- Input i is non-empty when in_rd_addr[i] != in_wr_addr[i]. Pointers wrap modulo 2^ADDR_W.
- Per-input state: IDLE, FWD(o), DROP.
- Per-output state: lock flag (out_busy[o]), owner index, round-robin pointer rr[o].
- At issue, for each IDLE non-empty input, inspect the head word h = in_data[i]:
  - h == 0: consume it (rd_addr+1), no write, stay IDLE.
  - dest = h[DW-1:0] ≥ NPORTS: consume it, go to DROP, and increment drop_count (saturate at 16'hFFFF).
  - otherwise: request output dest.
- Arbitration, per output o that is unlocked at the start of the issue:
  - Grant the requester found first scanning from index rr[o] upward, mod NPORTS.
  - The grantee goes to FWD(o). Set the lock and set rr[o] = grantee+1 mod NPORTS.
  - In the same issue, write the header word: out_data[o]=h, out_wr[o]=1, rd_addr+1.
  - Losers stay IDLE and consume nothing.
- FWD(o) input, non-empty, at issue: write in_data[i] to out_data[o], pulse out_wr[o], rd_addr+1.
  - If the word is zero (terminator), write it, clear the lock, and return to IDLE.
  - The freed output is grantable at the next issue, not the current one.
- DROP input, non-empty, at issue: consume the word with no write. A zero word returns the input to IDLE.
- Any input that is empty at issue stalls: no write, no pointer change, state held. This includes mid-packet.
- An input granted in an issue is not re-examined in that issue. Each input produces at most one word per issue.
- in_rden[i]=1 continuously while out of reset.

## Timing
- Reset (asynchronous assert, synchronous-release safe) clears all of:
  - slot counter, in_rd_addr, in_rden, out_data, out_wr, out_busy, drop_count, owners, and every rr pointer, all to 0
  - all inputs to IDLE
- A reset mid-packet abandons the partial packet. Downstream sees no terminator.
- out_wr pulses for exactly one clock: the cycle after the issue edge. out_data holds its value until the next write to that port.
- in_rd_addr updates on the issue edge. in_data must be valid by the next issue, PERIOD-1 cycles later.
- Latency from the header word being present at issue to the header appearing on out_wr: 1 clock.
- Throughput is one word per input per PERIOD clocks. Up to NPORTS outputs are written in parallel.
- enable=0 freezes all state. out_wr is 0 whenever no issue occurred in the previous cycle.

## Test plan
- **Single-input routing.** NPORTS=3, PERIOD=3. Input 0 holds header 0x00000002, 0xAAAA0000, 0x0 → three out_wr[2] pulses, 3 clocks apart, carrying those three words. Final in_rd_addr[0]=3 and out_busy[2] returns to 0.
- **Contention.** Inputs 0 and 1 both carry 2-word packets headed to output 1, rr[1]=0 → input 0 wins and is forwarded first. Input 1 is granted at the issue after input 0's terminator. rr[1] ends at 2.
- **Invalid destination.** Header 0x3 with NPORTS=3, followed by 0x55 then 0x0 → no out_wr on any port, drop_count=1, in_rd_addr advances by 3.
- **Mid-packet stall.** Write header and one data word, hold in_wr_addr for 4 issues, then append the terminator → no writes and no pointer movement during the stall. The terminator is forwarded at the first issue after it arrives.
- **Wrap-around.** ADDR_W=4, pointers start at 14, 3-word packet → in_rd_addr goes 15, 0, 1. Output data is correct and there is no false empty.
- **Reset mid-operation.** Assert reset_n=0 mid-packet → all outputs read 0 in the same cycle. After release, a new packet routes normally with rr pointers at 0.

Source files
------------

// File: rtl/switch_scheduler.sv
// Round-robin packet scheduler between NPORTS input packet RAMs and NPORTS output RAMs.
// Whole packets are routed by header destination, one word per input per issue slot.
module switch_scheduler #(
  parameter int NPORTS = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int PERIOD = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [NPORTS*DATA_W-1:0]         in_data,
  input  logic [NPORTS*ADDR_W-1:0]         in_wr_addr,
  output logic [NPORTS*ADDR_W-1:0]         in_rd_addr,
  output logic [NPORTS-1:0]                in_rden,
  output logic [NPORTS*DATA_W-1:0]         out_data,
  output logic [NPORTS-1:0]                out_wr,
  output logic [NPORTS-1:0]                out_busy,
  output logic [15:0]                      drop_count,
  output logic [2*NPORTS-1:0]              in_state,
  output logic [NPORTS*$clog2(NPORTS)-1:0] rr_ptr
);

  localparam int DW = $clog2(NPORTS);
  localparam int SW = $clog2(PERIOD);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PERIOD - 1);
  localparam logic [DW:0]   NP_W      = (DW+1)'(NPORTS);

  // in_state exposes one 2-bit code per input: 0 idle, 1 forwarding, 2 draining.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1, ST_DROP = 2'd2} in_st_t;

  logic [SW-1:0]     slot_q;
  logic              rden_q;
  logic              issue;
  in_st_t            st_q   [NPORTS];
  in_st_t            st_d   [NPORTS];
  logic [ADDR_W-1:0] rd_q   [NPORTS];
  logic [ADDR_W-1:0] rd_d   [NPORTS];
  logic [DATA_W-1:0] od_q   [NPORTS];
  logic [DATA_W-1:0] od_d   [NPORTS];
  logic [DW-1:0]     own_q  [NPORTS];
  logic [DW-1:0]     own_d  [NPORTS];
  logic [DW-1:0]     rr_q   [NPORTS];
  logic [DW-1:0]     rr_d   [NPORTS];
  logic [DATA_W-1:0] head   [NPORTS];
  logic [DW-1:0]     head_dst [NPORTS];
  logic [NPORTS-1:0] nonempty, valid_dst, cand, granted;
  logic [NPORTS-1:0] busy_q, busy_d, wr_q, wr_d;
  logic [15:0]       drop_q, drop_d;
  logic              found;
  logic [DW-1:0]     idx, gidx, oi;

  // RAM contract: in_data slice i must reflect in_rd_addr slice i by the next issue;
  // an input is non-empty whenever its read and write pointers differ (wrap-safe).
  assign issue = enable && (slot_q == SLOT_LAST);

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign head[g]      = in_data[g*DATA_W +: DATA_W];
    assign head_dst[g]  = head[g][DW-1:0];
    assign nonempty[g]  = rd_q[g] != in_wr_addr[g*ADDR_W +: ADDR_W];
    assign valid_dst[g] = {1'b0, head_dst[g]} < NP_W;
    assign cand[g]      = (st_q[g] == ST_IDLE) && nonempty[g] && (head[g] != '0) && valid_dst[g];
    assign in_rd_addr[g*ADDR_W +: ADDR_W] = rd_q[g];
    assign out_data[g*DATA_W +: DATA_W]   = od_q[g];
    assign in_state[2*g +: 2]             = st_q[g];
    assign rr_ptr[g*DW +: DW]             = rr_q[g];
  end

  assign in_rden    = {NPORTS{rden_q}};
  assign out_wr     = wr_q;
  assign out_busy   = busy_q;
  assign drop_count = drop_q;

  always_comb begin
    st_d    = st_q;
    rd_d    = rd_q;
    od_d    = od_q;
    own_d   = own_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    drop_d  = drop_q;
    wr_d    = '0;
    granted = '0;
    found   = 1'b0;
    idx     = '0;
    gidx    = '0;
    oi      = '0;
    if (issue) begin
      // Unlocked outputs arbitrate; locked ones pull the next word from their owner.
      for (int o = 0; o < NPORTS; o++) begin
        if (!busy_q[o]) begin
          found = 1'b0;
          gidx  = '0;
          for (int k = 0; k < NPORTS; k++) begin
            idx = DW'((int'(rr_q[o]) + k) % NPORTS);
            if (!found && cand[idx] && (head_dst[idx] == DW'(o))) begin
              found = 1'b1;
              gidx  = idx;
            end
          end
          if (found) begin
            granted[gidx] = 1'b1;
            st_d[gidx]    = ST_FWD;
            rd_d[gidx]    = rd_q[gidx] + ADDR_W'(1);
            busy_d[o]     = 1'b1;
            own_d[o]      = gidx;
            rr_d[o]       = DW'((int'(gidx) + 1) % NPORTS);
            od_d[o]       = head[gidx];
            wr_d[o]       = 1'b1;
          end
        end else begin
          oi = own_q[o];
          if (nonempty[oi]) begin
            od_d[o]  = head[oi];
            wr_d[o]  = 1'b1;
            rd_d[oi] = rd_q[oi] + ADDR_W'(1);
            if (head[oi] == '0) begin
              busy_d[o] = 1'b0;
              st_d[oi]  = ST_IDLE;
            end
          end
        end
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (nonempty[i] && !granted[i]) begin
          case (st_q[i])
            ST_IDLE: begin
              if (head[i] == '0) begin
                rd_d[i] = rd_q[i] + ADDR_W'(1);
              end else if (!valid_dst[i]) begin
                rd_d[i] = rd_q[i] + ADDR_W'(1);
                st_d[i] = ST_DROP;
                if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
              end
            end
            ST_DROP: begin
              rd_d[i] = rd_q[i] + ADDR_W'(1);
              if (head[i] == '0) st_d[i] = ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      rden_q <= 1'b0;
      busy_q <= '0;
      wr_q   <= '0;
      drop_q <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        st_q[i]  <= ST_IDLE;
        rd_q[i]  <= '0;
        od_q[i]  <= '0;
        own_q[i] <= '0;
        rr_q[i]  <= '0;
      end
    end else begin
      rden_q <= 1'b1;
      if (enable) slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      busy_q <= busy_d;
      wr_q   <= wr_d;
      drop_q <= drop_d;
      for (int i = 0; i < NPORTS; i++) begin
        st_q[i]  <= st_d[i];
        rd_q[i]  <= rd_d[i];
        od_q[i]  <= od_d[i];
        own_q[i] <= own_d[i];
        rr_q[i]  <= rr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_scheduler.sv
// Bench for switch_scheduler: directed scenarios plus randomized traffic against a
// queue-based reference model of the routing rules.
module tb_switch_scheduler;
  localparam int NP = 3;
  localparam int DATA_W = 32;
  localparam int AW = 4;
  localparam int PER = 3;

  logic                 clk, reset_n, enable;
  logic [NP*DATA_W-1:0] in_data, out_data;
  logic [NP*AW-1:0]     in_wr_addr, in_rd_addr;
  logic [NP-1:0]        in_rden, out_wr, out_busy;
  logic [15:0]          drop_count;
  logic [2*NP-1:0]      in_state;
  logic [2*NP-1:0]      rr_ptr;

  switch_scheduler #(.NPORTS(NP), .DATA_W(DATA_W), .ADDR_W(AW), .PERIOD(PER)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data),
    .in_wr_addr(in_wr_addr), .in_rd_addr(in_rd_addr), .in_rden(in_rden),
    .out_data(out_data), .out_wr(out_wr), .out_busy(out_busy),
    .drop_count(drop_count), .in_state(in_state), .rr_ptr(rr_ptr)
  );

  // ---------------- clock / environment RAMs ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DATA_W-1:0] ram [NP][16];
  logic [AW-1:0]     wp  [NP];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      in_data[i*DATA_W +: DATA_W] = ram[i][in_rd_addr[i*AW +: AW]];
      in_wr_addr[i*AW +: AW]      = wp[i];
    end
  end

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [31:0] q_in  [NP][$];
  logic [31:0] gen_q [NP][$];
  int          m_mode [NP];   // 0 idle, 1 forwarding, 2 draining
  int          m_dst  [NP];
  bit          m_busy [NP];
  int          m_rr   [NP];
  int          m_rd   [NP];
  logic [31:0] m_od   [NP];
  logic [NP-1:0] m_wr;
  int          m_drop, m_slot;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      q_in[i].delete();
      m_mode[i] = 0; m_dst[i] = 0; m_busy[i] = 0; m_rr[i] = 0; m_rd[i] = 0; m_od[i] = '0;
    end
    m_drop = 0; m_slot = 0; m_wr = '0;
  endfunction

  function automatic void model_issue();
    int snap [NP];
    bit sbusy [NP];
    bit gr [NP];
    logic [31:0] h;
    for (int i = 0; i < NP; i++) begin
      snap[i] = m_mode[i]; sbusy[i] = m_busy[i]; gr[i] = 0;
    end
    for (int o = 0; o < NP; o++) begin
      if (!sbusy[o]) begin
        for (int k = 0; k < NP; k++) begin
          int c;
          c = (m_rr[o] + k) % NP;
          if (!gr[c] && snap[c] == 0 && q_in[c].size() > 0 && q_in[c][0] != 0 &&
              int'(q_in[c][0][1:0]) == o) begin
            h = q_in[c].pop_front();
            m_rd[c] = (m_rd[c] + 1) % 16;
            m_mode[c] = 1; m_dst[c] = o; gr[c] = 1;
            m_busy[o] = 1; m_rr[o] = (c + 1) % NP;
            m_wr[o] = 1'b1; m_od[o] = h;
            break;
          end
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (!gr[i] && q_in[i].size() > 0) begin
        h = q_in[i][0];
        if (snap[i] == 0) begin
          if (h == 0) begin
            void'(q_in[i].pop_front()); m_rd[i] = (m_rd[i] + 1) % 16;
          end else if (int'(h[1:0]) >= NP) begin
            void'(q_in[i].pop_front()); m_rd[i] = (m_rd[i] + 1) % 16;
            m_mode[i] = 2;
            if (m_drop < 65535) m_drop++;
          end
        end else if (snap[i] == 1) begin
          void'(q_in[i].pop_front()); m_rd[i] = (m_rd[i] + 1) % 16;
          m_wr[m_dst[i]] = 1'b1; m_od[m_dst[i]] = h;
          if (h == 0) begin
            m_mode[i] = 0; m_busy[m_dst[i]] = 0;
          end
        end else begin
          void'(q_in[i].pop_front()); m_rd[i] = (m_rd[i] + 1) % 16;
          if (h == 0) m_mode[i] = 0;
        end
      end
    end
  endfunction

  function automatic void model_edge();
    m_wr = '0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (enable) begin
      if (m_slot == PER - 1) model_issue();
      m_slot = (m_slot + 1) % PER;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push(input int i, input logic [31:0] w);
    ram[i][wp[i]] = w;
    wp[i] = wp[i] + 4'd1;
    q_in[i].push_back(w);
  endtask

  task automatic gen_packet(input int i);
    int dest, len;
    logic [31:0] hdr;
    if ($urandom_range(0, 7) == 0) begin
      gen_q[i].push_back(32'h0);
      return;
    end
    dest = $urandom_range(0, 3);
    hdr  = (32'($urandom_range(1, 1023)) << 2) | 32'(dest);
    gen_q[i].push_back(hdr);
    len = $urandom_range(0, 3);
    repeat (len) gen_q[i].push_back($urandom | 32'h1);
    gen_q[i].push_back(32'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    for (int i = 0; i < NP; i++) begin
      wp[i] = '0;
      for (int a = 0; a < 16; a++) ram[i][a] = '0;
    end
    model_reset();
    repeat (3) tick();
    checks++;
    if ({out_wr, out_busy, in_rden, drop_count, in_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b busy=%b rden=%b drop=%0d rd=%h exp all zero",
               out_wr, out_busy, in_rden, drop_count, in_rd_addr);
    end
    checks++;
    if ({rr_ptr, in_state, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_state got rr=%h st=%h data=%h exp all zero", rr_ptr, in_state, out_data);
    end
    reset_n = 1'b1; enable = 1'b1;
    tick();
    checks++;
    if (in_rden !== 3'b111) begin
      errors++; $display("FAIL rden_after_reset got %b exp 111", in_rden);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_q[$];
    int last;
    exp_q = {32'h0000_0002, 32'hAAAA_0000, 32'h0};
    push(0, 32'h0000_0002); push(0, 32'hAAAA_0000); push(0, 32'h0);
    last = -1;
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++;
      if (out_wr[1:0] !== 2'b00) begin
        errors++; $display("FAIL single_stray got %b exp 00", out_wr[1:0]);
      end
      if (out_wr[2] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL single_extra got %h exp no write", out_data[95:64]);
        end else if (out_data[95:64] !== exp_q[0]) begin
          errors++; $display("FAIL single_data got %h exp %h", out_data[95:64], exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin
            errors++; $display("FAIL single_gap got %0d exp 3", c - last);
          end
        end
        last = c;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_count got %0d missing exp 0", exp_q.size());
    end
    checks++;
    if ({in_rd_addr[3:0], out_busy[2], rr_ptr[5:4]} !== {4'd3, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL single_final got rd=%0d busy=%b rr=%0d exp rd=3 busy=0 rr=1",
               in_rd_addr[3:0], out_busy[2], rr_ptr[5:4]);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_q[$];
    exp_q = {32'h1, 32'h11, 32'h0, 32'h101, 32'h22, 32'h0};
    push(0, 32'h1);   push(0, 32'h11); push(0, 32'h0);
    push(1, 32'h101); push(1, 32'h22); push(1, 32'h0);
    for (int c = 0; c < 25; c++) begin
      tick();
      if (out_wr[1] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || out_data[63:32] !== exp_q[0]) begin
          errors++;
          $display("FAIL contention_order got %h exp %h", out_data[63:32],
                   (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL contention_count got %0d missing exp 0", exp_q.size());
    end
    checks++;
    if ({rr_ptr[3:2], in_rd_addr[7:0], out_busy} !== {2'd2, 4'd3, 4'd6, 3'b000}) begin
      errors++;
      $display("FAIL contention_final got rr1=%0d rd=%h busy=%b exp rr1=2 rd=36 busy=000",
               rr_ptr[3:2], in_rd_addr[7:0], out_busy);
    end
  endtask

  task automatic test_invalid();
    push(2, 32'h3); push(2, 32'h55); push(2, 32'h0);
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++;
      if (out_wr !== 3'b000) begin
        errors++; $display("FAIL invalid_write got %b exp 000", out_wr);
      end
    end
    checks++;
    if ({drop_count, in_rd_addr[11:8], in_state[5:4]} !== {16'd1, 4'd3, 2'd0}) begin
      errors++;
      $display("FAIL invalid_final got drop=%0d rd=%0d st=%0d exp drop=1 rd=3 st=0",
               drop_count, in_rd_addr[11:8], in_state[5:4]);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] exp_q[$];
    exp_q = {32'h1, 32'h77, 32'h0};
    enable = 1'b0;
    push(0, 32'h1); push(0, 32'h77); push(0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({out_wr, in_rd_addr[3:0], out_busy} !== {3'b000, 4'd6, 3'b000}) begin
        errors++;
        $display("FAIL freeze_hold got wr=%b rd=%0d busy=%b exp wr=000 rd=6 busy=000",
                 out_wr, in_rd_addr[3:0], out_busy);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_wr[1] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || out_data[63:32] !== exp_q[0]) begin
          errors++; $display("FAIL freeze_data got %h exp %h", out_data[63:32],
                             (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL freeze_count got %0d missing exp 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_q[$];
    int seen;
    exp_q = {32'h102, 32'h33};
    push(0, 32'h102); push(0, 32'h33);
    seen = 0;
    for (int c = 0; c < 15 && seen < 2; c++) begin
      tick();
      if (out_wr[2] === 1'b1) begin
        checks++;
        if (out_data[95:64] !== exp_q[0]) begin
          errors++; $display("FAIL stall_lead got %h exp %h", out_data[95:64], exp_q[0]);
        end
        void'(exp_q.pop_front());
        seen++;
      end
    end
    checks++;
    if (seen != 2) begin
      errors++; $display("FAIL stall_start got %0d words exp 2", seen);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({out_wr, in_rd_addr[3:0], out_busy[2]} !== {3'b000, 4'd11, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold got wr=%b rd=%0d busy=%b exp wr=000 rd=11 busy=1",
                 out_wr, in_rd_addr[3:0], out_busy[2]);
      end
    end
    push(0, 32'h0);
    seen = 0;
    for (int c = 0; c < 3 && seen == 0; c++) begin
      tick();
      if (out_wr[2] === 1'b1) begin
        seen = 1;
        checks++;
        if (out_data[95:64] !== 32'h0) begin
          errors++; $display("FAIL stall_term got %h exp 0", out_data[95:64]);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL stall_resume got no write within 3 clocks exp 1 write");
    end
    checks++;
    if ({out_busy[2], in_rd_addr[3:0]} !== {1'b0, 4'd12}) begin
      errors++; $display("FAIL stall_final got busy=%b rd=%0d exp busy=0 rd=12",
                         out_busy[2], in_rd_addr[3:0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    logic [3:0]  exp_rd[$];
    repeat (11) push(1, 32'h0);
    for (int c = 0; c < 36; c++) begin
      tick();
      checks++;
      if (out_wr !== 3'b000) begin
        errors++; $display("FAIL wrap_fill got %b exp 000", out_wr);
      end
    end
    checks++;
    if (in_rd_addr[7:4] !== 4'd14) begin
      errors++; $display("FAIL wrap_start got %0d exp 14", in_rd_addr[7:4]);
    end
    exp_q  = {32'h4, 32'hBEEF, 32'h0};
    exp_rd = {4'd15, 4'd0, 4'd1};
    push(1, 32'h4); push(1, 32'hBEEF); push(1, 32'h0);
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_wr[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || {out_data[31:0], in_rd_addr[7:4]} !== {exp_q[0], exp_rd[0]}) begin
          errors++;
          $display("FAIL wrap_word got data=%h rd=%0d exp data=%h rd=%0d", out_data[31:0],
                   in_rd_addr[7:4], (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF,
                   (exp_rd.size() > 0) ? exp_rd[0] : 4'hF);
        end
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front()); void'(exp_rd.pop_front());
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_count got %0d missing exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_q[$];
    int seen;
    push(2, 32'h1); push(2, 32'h99);
    seen = 0;
    for (int c = 0; c < 15 && seen < 2; c++) begin
      tick();
      if (out_wr[1] === 1'b1) seen++;
    end
    checks++;
    if (seen != 2) begin
      errors++; $display("FAIL resetmid_start got %0d words exp 2", seen);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_wr, out_busy, in_rden, drop_count, in_rd_addr, out_data, rr_ptr} !== '0) begin
      errors++;
      $display("FAIL resetmid_clear got wr=%b busy=%b rden=%b drop=%0d rd=%h rr=%h exp all zero",
               out_wr, out_busy, in_rden, drop_count, in_rd_addr, rr_ptr);
    end
    for (int i = 0; i < NP; i++) wp[i] = '0;
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({rr_ptr, in_state} !== '0) begin
      errors++; $display("FAIL resetmid_rr got rr=%h st=%h exp 0", rr_ptr, in_state);
    end
    exp_q = {32'h4, 32'h5A, 32'h0};
    push(1, 32'h4); push(1, 32'h5A); push(1, 32'h0);
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_wr[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || out_data[31:0] !== exp_q[0]) begin
          errors++; $display("FAIL resetmid_data got %h exp %h", out_data[31:0],
                             (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0 || rr_ptr[1:0] !== 2'd2) begin
      errors++; $display("FAIL resetmid_final got missing=%0d rr0=%0d exp missing=0 rr0=2",
                         exp_q.size(), rr_ptr[1:0]);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0]        e_busy;
    logic [NP*AW-1:0]     e_rd;
    logic [NP*DATA_W-1:0] e_od;
    for (int c = 0; c < 1200; c++) begin
      if (c < 1100) begin
        enable = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < NP; i++) begin
          if (gen_q[i].size() == 0) gen_packet(i);
          if (q_in[i].size() < 12 && $urandom_range(0, 1) == 1) push(i, gen_q[i].pop_front());
        end
      end else begin
        enable = 1'b1;
      end
      tick();
      for (int i = 0; i < NP; i++) begin
        e_busy[i] = m_busy[i];
        e_rd[i*AW +: AW] = AW'(m_rd[i]);
        e_od[i*DATA_W +: DATA_W] = m_od[i];
      end
      checks++;
      if ({out_wr, out_busy, in_rd_addr, drop_count} !== {m_wr, e_busy, e_rd, 16'(m_drop)}) begin
        errors++;
        $display("FAIL random_ctl cyc %0d got wr=%b busy=%b rd=%h drop=%0d exp wr=%b busy=%b rd=%h drop=%0d",
                 c, out_wr, out_busy, in_rd_addr, drop_count, m_wr, e_busy, e_rd, m_drop);
      end
      checks++;
      if (out_data !== e_od) begin
        errors++; $display("FAIL random_data cyc %0d got %h exp %h", c, out_data, e_od);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_invalid();
    test_freeze();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
